// File: rtl/sfifo_pop_stream_if.sv
// FIFO pop-side and output-stream signal bundle for sfifo_pop_stream.
// master = the stream adapter, slave = FIFO plus stream sink.
interface sfifo_pop_stream_if #(
    parameter int FIFO_W = 32,
    parameter int OCC_W  = 2
);
    logic              fifo_empt;
    logic              fifo_re;
    logic [FIFO_W-1:0] fifo_rd;
    logic              fifo_fsh;
    logic              m_vld;
    logic [FIFO_W-1:0] m_dat;
    logic              m_rdy;
    logic [OCC_W-1:0]  m_occ;

    modport master (
        input  fifo_empt, fifo_rd, fifo_fsh, m_rdy,
        output fifo_re, m_vld, m_dat, m_occ
    );

    modport slave (
        output fifo_empt, fifo_rd, fifo_fsh, m_rdy,
        input  fifo_re, m_vld, m_dat, m_occ
    );
endinterface

// File: rtl/sfifo_pop_stream.sv
// Drains a fixed-latency FIFO pop port into a valid/ready stream,
// hiding the read latency with a small credit-checked circular buffer.
module sfifo_pop_stream #(
    parameter int FIFO_W   = 32,
    parameter int FIFO_DLY = 0,
    parameter int BUF_D    = FIFO_DLY + 2
) (
    input logic                clk,
    input logic                rst,
    sfifo_pop_stream_if.master bus
);
    localparam int OCC_W = $clog2(BUF_D + 1);
    localparam int PTR_W = $clog2(BUF_D);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_D - 1);
    localparam logic [OCC_W:0]   OCC_LIM  = (OCC_W + 1)'(BUF_D);

    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [OCC_W-1:0]  infl;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_W-1:0] mem_q [BUF_D];
    logic              re;
    logic              cap;
    logic              vld;
    logic              xfer;

    // Credit check uses registered state only, so m_rdy never reaches fifo_re.
    assign re = !rst && !bus.fifo_empt && !bus.fifo_fsh &&
                (({1'b0, occ_q} + {1'b0, infl}) < OCC_LIM);

    generate
        if (FIFO_DLY == 0) begin : g_nodly
            assign cap  = re;
            assign infl = '0;
        end else begin : g_dly
            logic [FIFO_DLY-1:0] sr_q, sr_d;

            always_comb begin
                sr_d = '0;
                if (!bus.fifo_fsh) begin
                    sr_d[0] = re;
                    for (int i = 1; i < FIFO_DLY; i++) begin
                        sr_d[i] = sr_q[i-1];
                    end
                end
            end

            always_comb begin
                infl = '0;
                for (int i = 0; i < FIFO_DLY; i++) begin
                    infl = infl + OCC_W'(sr_q[i]);
                end
            end

            assign cap = sr_q[FIFO_DLY-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr_q <= '0;
                end else begin
                    sr_q <= sr_d;
                end
            end
        end
    endgenerate

    assign vld  = (occ_q != '0);
    assign xfer = vld && bus.m_rdy;

    always_comb begin
        occ_d    = occ_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (bus.fifo_fsh) begin
            occ_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (cap) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (xfer) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            unique case ({cap, xfer})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            occ_q    <= occ_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (cap && !bus.fifo_fsh) begin
            mem_q[wr_ptr_q] <= bus.fifo_rd;
        end
    end

    assign bus.fifo_re = re;
    assign bus.m_vld   = vld;
    assign bus.m_dat   = vld ? mem_q[rd_ptr_q] : '0;
    assign bus.m_occ   = occ_q;
endmodule

// File: tb/tb_sfifo_pop_stream.sv
// Directed bench for sfifo_pop_stream with FIFO_DLY=2 (BUF_D=4):
// FIFO model with 2-cycle read latency, scoreboard queue of expected words.
module tb_sfifo_pop_stream;
    localparam int W   = 32;
    localparam int DLY = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sfifo_pop_stream_if #(.FIFO_W(W), .OCC_W(3)) bus ();

    sfifo_pop_stream #(.FIFO_W(W), .FIFO_DLY(DLY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] fifo_q [$];
    logic [W-1:0] exp_q  [$];
    logic [W-1:0] pipe0;
    logic [W-1:0] pipe1;
    int navail    = 0;
    int pops      = 0;
    int delivered = 0;
    int n_chk     = 0;
    int n_fail    = 0;

    assign bus.fifo_empt = (navail == 0);
    assign bus.fifo_rd   = pipe1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + W'(i));
            exp_q.push_back(base + W'(i));
        end
        navail <= navail + n;
    endtask

    task automatic wait_occ(input int v, input string tag);
        for (int i = 0; i < 20; i++) begin
            if (int'(bus.m_occ) == v) break;
            step();
        end
        check(tag, 32'(bus.m_occ), v);
    endtask

    task automatic wait_drain(input int max, input string tag);
        for (int i = 0; i < max; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        check(tag, exp_q.size(), 0);
    endtask

    // FIFO with a two-cycle read pipeline; flush empties it.
    initial begin
        pipe0 <= '0;
        pipe1 <= '0;
        forever begin
            @(posedge clk);
            pipe1 <= pipe0;
            if (bus.fifo_fsh) begin
                fifo_q.delete();
                navail <= 0;
                pipe0  <= 32'hDEADBEEF;
            end else if (bus.fifo_re) begin
                pops = pops + 1;
                if (fifo_q.size() != 0) begin
                    pipe0  <= fifo_q.pop_front();
                    navail <= navail - 1;
                end else begin
                    pipe0 <= 32'hBAD0BAD0;
                end
            end else begin
                pipe0 <= 32'hDEADBEEF;
            end
        end
    end

    // Stream monitor: head must always match the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                check("occ_max", 32'(bus.m_occ <= 3'd4), 1);
                if (bus.m_vld) begin
                    if (exp_q.size() == 0) begin
                        check("extra_word", 32'(bus.m_vld), 0);
                    end else begin
                        check("m_dat", bus.m_dat, exp_q[0]);
                        if (bus.m_rdy) begin
                            void'(exp_q.pop_front());
                            delivered++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int d0;

        rst          = 1'b1;
        bus.m_rdy    = 1'b0;
        bus.fifo_fsh = 1'b0;
        #1;
        check("rst_vld", 32'(bus.m_vld), 0);
        check("rst_occ", 32'(bus.m_occ), 0);
        check("rst_dat", bus.m_dat, 0);
        check("rst_re", 32'(bus.fifo_re), 0);

        repeat (2) step();
        load(32'h1, 8);
        #1;
        check("re_in_rst", 32'(bus.fifo_re), 0);

        // Preloaded FIFO, sink always ready
        bus.m_rdy = 1'b1;
        step();
        rst = 1'b0;
        p0  = pops;
        #1;
        check("re_cycle0", 32'(bus.fifo_re), 1);
        step();
        check("vld_c1", 32'(bus.m_vld), 0);
        step();
        check("vld_c2", 32'(bus.m_vld), 0);
        step();
        check("vld_c3", 32'(bus.m_vld), 1);
        for (int i = 0; i < 7; i++) begin
            step();
            check("thru_vld", 32'(bus.m_vld), 1);
        end
        step();
        check("vld_c11", 32'(bus.m_vld), 0);
        check("pops_8", pops - p0, 8);
        check("sb_8", exp_q.size(), 0);

        // Empty FIFO: nothing popped, nothing presented
        p0 = pops;
        repeat (10) step();
        check("empty_pops", pops - p0, 0);
        check("empty_vld", 32'(bus.m_vld), 0);
        check("empty_re", 32'(bus.fifo_re), 0);

        // Backpressure until the buffer fills
        bus.m_rdy = 1'b0;
        p0 = pops;
        d0 = delivered;
        load(32'h10, 8);
        repeat (10) step();
        check("bp_pops", pops - p0, 4);
        check("bp_occ", 32'(bus.m_occ), 4);
        check("bp_dat", bus.m_dat, 32'h10);
        check("bp_re", 32'(bus.fifo_re), 0);
        bus.m_rdy = 1'b1;
        wait_drain(40, "bp_drain");
        check("bp_deliv", delivered - d0, 8);

        // Ready toggling every cycle
        d0 = delivered;
        load(32'h20, 16);
        for (int i = 0; i < 80; i++) begin
            if (exp_q.size() == 0) break;
            bus.m_rdy = ~bus.m_rdy;
            step();
        end
        check("tog_drain", exp_q.size(), 0);
        check("tog_deliv", delivered - d0, 16);

        // Flush with words both buffered and in flight
        bus.m_rdy = 1'b0;
        load(32'h60, 6);
        wait_occ(1, "pre_fsh_occ");
        check("pre_fsh_vld", 32'(bus.m_vld), 1);
        bus.fifo_fsh = 1'b1;
        #1;
        check("fsh_re", 32'(bus.fifo_re), 0);
        step();
        bus.fifo_fsh = 1'b0;
        exp_q.delete();
        check("fsh_vld", 32'(bus.m_vld), 0);
        check("fsh_occ", 32'(bus.m_occ), 0);
        repeat (3) step();
        check("fsh_infl", 32'(bus.m_occ), 0);
        d0 = delivered;
        load(32'h50, 4);
        bus.m_rdy = 1'b1;
        wait_drain(20, "fsh_drain");
        check("fsh_deliv", delivered - d0, 4);

        // Asynchronous reset mid-stream
        bus.m_rdy = 1'b0;
        load(32'h40, 6);
        wait_occ(2, "pre_rst_occ");
        rst = 1'b1;
        #1;
        check("arst_vld", 32'(bus.m_vld), 0);
        check("arst_occ", 32'(bus.m_occ), 0);
        check("arst_re", 32'(bus.fifo_re), 0);
        check("arst_dat", bus.m_dat, 0);
        exp_q = fifo_q;
        step();
        step();
        check("arst_hold_re", 32'(bus.fifo_re), 0);
        d0 = delivered;
        rst = 1'b0;
        bus.m_rdy = 1'b1;
        wait_drain(20, "arst_drain");
        check("arst_deliv", delivered - d0, 2);

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
